fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch reader for the multicycle MIPS datapath. It reads the current program counter and issues a req/ack read to instruction memory. It latches the returned word into the instruction register, computes PC+4, and pulses a one-cycle PC write enable that drives the program counter register's enable input. The multicycle control FSM starts it with a single pulse.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction words
RESET_PC, 32'h00400000, reset value of mem_addr_o and pc_plus4_o (text segment base)
TIMEOUT_CYCLES, 16, REQ-state cycles without ack before abort (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
fetch_start  input  1  one-cycle pulse from control FSM; begin a fetch
pc_i  input  DATA_WIDTH  current PC value (output of the PC register)
mem_req_o  output  1  read request to instruction memory
mem_addr_o  output  DATA_WIDTH  read address, held stable while mem_req_o=1
mem_ack_i  input  1  memory read data valid / request accepted
mem_rdata_i  input  DATA_WIDTH  memory read data, valid when mem_ack_i=1
instr_o  output  DATA_WIDTH  instruction register
pc_plus4_o  output  DATA_WIDTH  fetched address + 4; data input of the PC register
pc_write_o  output  1  one-cycle enable to the PC register
fetch_done_o  output  1  one-cycle completion pulse to the control FSM
busy_o  output  1  high in any state other than IDLE
misaligned_o  output  1  sticky flag: last accepted PC had nonzero bits [1:0]
timeout_o  output  1  sticky flag: last fetch aborted by timeout (constant 0 when the feature is compiled out)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
- Reset (rst=0, asynchronous): state=IDLE.
  - instr_o=0; mem_addr_o=RESET_PC; pc_plus4_o=RESET_PC.
  - mem_req_o, pc_write_o, fetch_done_o, busy_o, misaligned_o and timeout_o all 0.
- Reset mid-fetch: the fetch is aborted immediately, mem_req_o drops without waiting for a clock edge, and no pc_write is produced.
- States: IDLE, REQ, DONE.
- IDLE, fetch_start=1:
  - Capture pc_i into mem_addr_o; clear misaligned_o and timeout_o.
  - If pc_i[1:0]!=0: set misaligned_o and go to DONE with no memory request. pc_write_o stays 0 in that DONE cycle and instr_o is unchanged.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1 and mem_addr_o is stable.
  - mem_req_o stays high until a rising edge with mem_ack_i=1.
  - On that edge: instr_o<=mem_rdata_i; pc_plus4_o<=mem_addr_o+4, modulo 2^DATA_WIDTH (0xFFFFFFFC wraps to 0x00000000); next state DONE.
- DONE: lasts exactly one cycle. fetch_done_o=1, pc_write_o=1 (0 for a misaligned fetch), mem_req_o=0, then go to IDLE.
- Latency with zero-wait memory: start sampled at edge N; mem_req_o high during cycle N..N+1; ack sampled at edge N+1; DONE pulses during cycle N+1..N+2; idle at N+2. Each memory wait cycle adds one cycle.
- fetch_start while busy_o=1 is ignored; no queuing.
- mem_ack_i outside REQ is ignored, including a late ack after an abort.
- Flag lifetime: instr_o and pc_plus4_o hold their values until the next successful fetch. misaligned_o and timeout_o hold until the next accepted fetch_start or reset.
- Every output is registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments every REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, mem_req_o drops, timeout_o sets, and the block goes to DONE with pc_write_o=0. instr_o and pc_plus4_o are unchanged.
  - An ack on the same edge as expiry wins: it is a normal completion.
- Undefined: there is no counter, REQ waits indefinitely, and timeout_o is tied to 0.

Test Plan:
- Reset release -> instr_o=0, mem_addr_o=pc_plus4_o=0x00400000, all strobes and flags 0.
- pc_i=0x00400000, fetch_start pulse, ack on the first REQ cycle with rdata=0x8C080004:
  - mem_req_o high for exactly one cycle.
  - instr_o=0x8C080004 and pc_plus4_o=0x00400004.
  - pc_write_o and fetch_done_o each high for one cycle, 2 cycles after start.
- pc_i=0x00400010, ack delayed 3 cycles, extra fetch_start pulses during REQ:
  - mem_req_o held 4 cycles with mem_addr_o stable.
  - Extra starts ignored; exactly one done pulse.
- pc_i=0x00400002 -> misaligned_o=1, no mem_req_o, fetch_done_o pulse with pc_write_o=0. The next aligned fetch clears misaligned_o.
- pc_i=0xFFFFFFFC with ack -> pc_plus4_o=0x00000000. Separately, rst asserted mid-REQ -> mem_req_o falls asynchronously, no pc_write_o; a stray ack afterwards has no effect.
- FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no ack:
  - mem_req_o drops after 16 REQ cycles.
  - timeout_o=1, fetch_done_o pulse, pc_write_o=0, instr_o unchanged.
  - A late ack is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch reader for the multicycle MIPS datapath: PC -> req/ack memory read -> IR, PC+4, PC write pulse.
// Optional FETCH_TIMEOUT_EN macro adds a REQ-state watchdog that aborts a fetch after TIMEOUT_CYCLES without ack.
module fetch_unit #(
    parameter int unsigned          DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h00400000,
    parameter int unsigned          TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_start,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  pc_write_o,
    output logic                  fetch_done_o,
    output logic                  busy_o,
    output logic                  misaligned_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                  mem_req_q, mem_req_d;
    logic                  pc_write_q, pc_write_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  busy_q, busy_d;
    logic                  misaligned_q, misaligned_d;
    logic                  timeout_q, timeout_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        instr_d      = instr_q;
        pc_plus4_d   = pc_plus4_q;
        misaligned_d = misaligned_q;
        timeout_d    = timeout_q;
        mem_req_d    = 1'b0;
        pc_write_d   = 1'b0;
        fetch_done_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_start) begin
                    mem_addr_d   = pc_i;
                    misaligned_d = 1'b0;
                    timeout_d    = 1'b0;
                    if (pc_i[1:0] != 2'b00) begin
                        // Misaligned: skip memory, report completion without a PC write
                        misaligned_d = 1'b1;
                        fetch_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    instr_d      = mem_rdata_i;
                    pc_plus4_d   = mem_addr_q + DATA_WIDTH'(4);
                    pc_write_d   = 1'b1;
                    fetch_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    // cnt_q counts completed REQ cycles; this edge ends cycle cnt_q+1
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_req_d    = 1'b0;
                        timeout_d    = 1'b1;
                        fetch_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_addr_q   <= RESET_PC;
            instr_q      <= '0;
            pc_plus4_q   <= RESET_PC;
            mem_req_q    <= 1'b0;
            pc_write_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            busy_q       <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            instr_q      <= instr_d;
            pc_plus4_q   <= pc_plus4_d;
            mem_req_q    <= mem_req_d;
            pc_write_q   <= pc_write_d;
            fetch_done_q <= fetch_done_d;
            busy_q       <= busy_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign instr_o      = instr_q;
    assign pc_plus4_o   = pc_plus4_q;
    assign pc_write_o   = pc_write_q;
    assign fetch_done_o = fetch_done_q;
    assign busy_o       = busy_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; covers the timeout path when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_start = 1'b0;
    logic [31:0] pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        pc_write_o;
    logic        fetch_done_o;
    logic        busy_o;
    logic        misaligned_o;
    logic        timeout_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    fetch_unit #(
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h00400000),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_start  (fetch_start),
        .pc_i         (pc_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .instr_o      (instr_o),
        .pc_plus4_o   (pc_plus4_o),
        .pc_write_o   (pc_write_o),
        .fetch_done_o (fetch_done_o),
        .busy_o       (busy_o),
        .misaligned_o (misaligned_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
        if (fetch_done_o) n_done++;
    endtask

    task automatic start(input logic [31:0] pc);
        pc_i        = pc;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    initial begin
        #23;
        chk("rst_req",   32'(mem_req_o), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_addr",  mem_addr_o, 32'h00400000);
        chk("rst_pc4",   pc_plus4_o, 32'h00400000);
        chk("rst_strb",  {27'd0, mem_req_o, pc_write_o, fetch_done_o, busy_o, misaligned_o}, 32'd0);
        chk("rst_to",    32'(timeout_o), 32'd0);

        // zero-wait fetch
        start(32'h00400000);
        chk("f1_req",   32'(mem_req_o), 32'd1);
        chk("f1_busy",  32'(busy_o), 32'd1);
        chk("f1_addr",  mem_addr_o, 32'h00400000);
        chk("f1_done0", 32'(fetch_done_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h8C080004;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'hDEADBEEF;
        chk("f1_req_off", 32'(mem_req_o), 32'd0);
        chk("f1_done",  32'(fetch_done_o), 32'd1);
        chk("f1_pcw",   32'(pc_write_o), 32'd1);
        chk("f1_instr", instr_o, 32'h8C080004);
        chk("f1_pc4",   pc_plus4_o, 32'h00400004);
        tick();
        chk("f1_done_1cyc", 32'(fetch_done_o), 32'd0);
        chk("f1_pcw_1cyc",  32'(pc_write_o), 32'd0);
        chk("f1_idle",      32'(busy_o), 32'd0);

        // 3 wait cycles, with extra starts during REQ
        n_done = 0;
        start(32'h00400010);
        for (int i = 0; i < 3; i++) begin
            chk("f2_req_hold",  32'(mem_req_o), 32'd1);
            chk("f2_addr_hold", mem_addr_o, 32'h00400010);
            pc_i        = 32'h00400100;
            fetch_start = (i != 1);
            tick();
            fetch_start = 1'b0;
        end
        chk("f2_req4", 32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h24090007;
        tick();
        mem_ack_i = 1'b0;
        chk("f2_done",  32'(fetch_done_o), 32'd1);
        chk("f2_instr", instr_o, 32'h24090007);
        chk("f2_pc4",   pc_plus4_o, 32'h00400014);
        for (int i = 0; i < 3; i++) tick();
        chk("f2_one_done", 32'(n_done), 32'd1);
        chk("f2_idle", 32'(busy_o | mem_req_o), 32'd0);

        // misaligned
        start(32'h00400002);
        chk("mis_flag",  32'(misaligned_o), 32'd1);
        chk("mis_noreq", 32'(mem_req_o), 32'd0);
        chk("mis_done",  32'(fetch_done_o), 32'd1);
        chk("mis_pcw",   32'(pc_write_o), 32'd0);
        chk("mis_instr", instr_o, 32'h24090007);
        chk("mis_pc4",   pc_plus4_o, 32'h00400014);
        tick();
        chk("mis_idle",  32'(busy_o), 32'd0);
        chk("mis_stick", 32'(misaligned_o), 32'd1);

        // wrap fetch clears misaligned
        start(32'hFFFFFFFC);
        chk("wrap_misclr", 32'(misaligned_o), 32'd0);
        chk("wrap_req",    32'(mem_req_o), 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h00000000;
        tick();
        mem_ack_i = 1'b0;
        chk("wrap_pc4", pc_plus4_o, 32'h00000000);
        chk("wrap_pcw", 32'(pc_write_o), 32'd1);
        tick();

        // reset in the middle of REQ
        start(32'h00400020);
        chk("rr_req", 32'(mem_req_o), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rr_async_req",  32'(mem_req_o), 32'd0);
        chk("rr_async_busy", 32'(busy_o), 32'd0);
        chk("rr_addr",       mem_addr_o, 32'h00400000);
        tick();
        rst = 1'b1;
        n_done = 0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h11111111;
        tick();
        chk("rr_stray_pcw", 32'(pc_write_o), 32'd0);
        tick();
        mem_ack_i = 1'b0;
        chk("rr_stray_instr", instr_o, 32'h0);
        chk("rr_stray_done",  32'(n_done), 32'd0);
        chk("rr_stray_req",   32'(mem_req_o), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        start(32'h00400040);
        for (int i = 0; i < 16; i++) begin
            chk("to_req_hold", 32'(mem_req_o), 32'd1);
            tick();
        end
        chk("to_req_drop", 32'(mem_req_o), 32'd0);
        chk("to_flag",     32'(timeout_o), 32'd1);
        chk("to_done",     32'(fetch_done_o), 32'd1);
        chk("to_pcw",      32'(pc_write_o), 32'd0);
        chk("to_instr",    instr_o, 32'h0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
        tick();
        tick();
        mem_ack_i = 1'b0;
        chk("to_late_instr", instr_o, 32'h0);
        chk("to_late_pc4",   pc_plus4_o, 32'h00400000);
        chk("to_stick",      32'(timeout_o), 32'd1);
`else
        start(32'h00400040);
        for (int i = 0; i < 20; i++) tick();
        chk("nto_req_wait", 32'(mem_req_o), 32'd1);
        chk("nto_flag",     32'(timeout_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h22222222;
        tick();
        mem_ack_i = 1'b0;
        chk("nto_instr", instr_o, 32'h22222222);
        chk("nto_pc4",   pc_plus4_o, 32'h00400044);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
